// File: rtl/passcode_lock_fsm_pkg.sv
// Shared definitions for the passcode lock.
//   state_e     : FSM states; encodings equal the o_Answer status codes
//   ANS_*       : answer codes seen by the downstream seven-segment decoder
//   DEF_*_CLKS  : default dwell times at 25 MHz
//   press_t     : one-cycle press strobes from the switch edge detectors
//   max3()      : sizes the shared dwell timer
package passcode_lock_fsm_pkg;

  localparam logic [2:0] ANS_IDLE    = 3'd0;
  localparam logic [2:0] ANS_ENTRY   = 3'd1;
  localparam logic [2:0] ANS_OPEN    = 3'd2;
  localparam logic [2:0] ANS_FAIL    = 3'd3;
  localparam logic [2:0] ANS_LOCKOUT = 3'd4;
  localparam logic [2:0] ANS_PROG    = 3'd5;

  // State encodings are the answer codes, so o_Answer is just the next state.
  typedef enum logic [2:0] {
    S_IDLE    = ANS_IDLE,
    S_ENTRY   = ANS_ENTRY,
    S_OPEN    = ANS_OPEN,
    S_FAIL    = ANS_FAIL,
    S_LOCKOUT = ANS_LOCKOUT,
    S_PROG    = ANS_PROG
  } state_e;

  localparam int NUM_SW           = 3;
  localparam int DEF_OPEN_CLKS    = 125_000_000;
  localparam int DEF_FAIL_CLKS    = 50_000_000;
  localparam int DEF_LOCKOUT_CLKS = 250_000_000;

  typedef struct packed {
    logic prog;
    logic clear;
    logic enter;
  } press_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_press_detect.sv
// Registered rising-edge detector for one debounced switch.
//   clk   : system clock
//   rst_l : synchronous active-low reset
//   level : debounced switch level
//   press : high for the cycle in which level is 1 and was 0 last cycle
// The previous level resets to 1 so a switch held through reset is not a press.
module lock_press_detect (
  input  logic clk,
  input  logic rst_l,
  input  logic level,
  output logic press
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_l) prev <= 1'b1;
    else        prev <= level;
  end

  assign press = level & ~prev;

endmodule

// File: rtl/passcode_lock_fsm.sv
// Four-digit passcode lock controller.
//   i_Clk, i_Rst_L     : clock, synchronous active-low reset
//   i_Switch_Enter     : rising edge captures i_Digit
//   i_Switch_Clear     : rising edge aborts entry / relocks
//   i_Switch_Prog      : rising edge while OPEN starts reprogramming
//   i_Digit            : digit from the upstream counter
//   o_LED_1..o_LED_4   : digit-captured progress LEDs
//   o_Answer           : status code (see ANS_* in the package)
//   o_Unlocked         : high only while OPEN
// All outputs are registered from the next state and index, so they change on
// the same edge that acts on a press.
module passcode_lock_fsm
  import passcode_lock_fsm_pkg::*;
#(
  parameter logic [15:0] CODE         = 16'h1234,
  parameter int          MAX_FAILS    = 3,
  parameter int          OPEN_CLKS    = DEF_OPEN_CLKS,
  parameter int          FAIL_CLKS    = DEF_FAIL_CLKS,
  parameter int          LOCKOUT_CLKS = DEF_LOCKOUT_CLKS
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_Enter,
  input  logic       i_Switch_Clear,
  input  logic       i_Switch_Prog,
  input  logic [3:0] i_Digit,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [2:0] o_Answer,
  output logic       o_Unlocked
);

  localparam int TMR_W = $clog2(max3(OPEN_CLKS, FAIL_CLKS, LOCKOUT_CLKS));

  logic [NUM_SW-1:0] sw_lvl, sw_press;
  press_t            pr;

  assign sw_lvl = {i_Switch_Prog, i_Switch_Clear, i_Switch_Enter};
  assign pr     = press_t'(sw_press);

  for (genvar g = 0; g < NUM_SW; g++) begin : g_pd
    lock_press_detect u_pd (
      .clk   (i_Clk),
      .rst_l (i_Rst_L),
      .level (sw_lvl[g]),
      .press (sw_press[g])
    );
  end

  state_e           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [3:0][3:0]  slots, slots_nxt;   // slot 0 lives in [3], matching CODE[15:12]
  logic [2:0]       fails, fails_nxt, fails_inc;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [15:0]      code, code_nxt, entered;
  logic [3:0]       leds_q, leds_nxt;
  logic [2:0]       ans_nxt;
  logic             unl_nxt;

  // Full word as it will stand once the current digit lands in slot 3.
  assign entered   = {slots[3], slots[2], slots[1], i_Digit};
  assign fails_inc = fails + 3'd1;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    slots_nxt = slots;
    fails_nxt = fails;
    tmr_nxt   = tmr;
    code_nxt  = code;
    case (state)
      S_IDLE: begin
        if (pr.enter) begin
          slots_nxt[3] = i_Digit;
          idx_nxt      = 2'd1;
          state_nxt    = S_ENTRY;
        end
      end
      S_ENTRY, S_PROG: begin
        if (pr.clear) begin
          state_nxt = S_IDLE;
          idx_nxt   = 2'd0;
        end else if (pr.enter) begin
          slots_nxt[2'd3 - idx] = i_Digit;
          idx_nxt               = idx + 2'd1;   // wraps to 0 on the 4th capture
          if (idx == 2'd3) begin
            if (state == S_PROG) begin
              code_nxt  = entered;
              state_nxt = S_IDLE;
            end else if (entered == code) begin
              state_nxt = S_OPEN;
              fails_nxt = 3'd0;
              tmr_nxt   = TMR_W'(OPEN_CLKS - 1);
            end else if (fails_inc == 3'(MAX_FAILS)) begin
              state_nxt = S_LOCKOUT;
              fails_nxt = 3'd0;
              tmr_nxt   = TMR_W'(LOCKOUT_CLKS - 1);
            end else begin
              state_nxt = S_FAIL;
              fails_nxt = fails_inc;
              tmr_nxt   = TMR_W'(FAIL_CLKS - 1);
            end
          end
        end
      end
      S_OPEN: begin
        if (pr.clear) begin
          state_nxt = S_IDLE;
        end else if (pr.prog) begin
          state_nxt = S_PROG;
          idx_nxt   = 2'd0;
        end else if (tmr == '0) begin
          state_nxt = S_IDLE;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_FAIL, S_LOCKOUT: begin
        if (tmr == '0) state_nxt = S_IDLE;
        else           tmr_nxt   = tmr - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    ans_nxt  = 3'(state_nxt);
    unl_nxt  = (state_nxt == S_OPEN);
    leds_nxt = 4'b0000;
    case (state_nxt)
      S_ENTRY, S_PROG:
        for (int k = 0; k < 4; k++) leds_nxt[k] = ({1'b0, idx_nxt} >= 3'(k + 1));
      S_OPEN:  leds_nxt = 4'b1111;
      default: leds_nxt = 4'b0000;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      slots      <= '0;
      fails      <= 3'd0;
      tmr        <= '0;
      code       <= CODE;
      leds_q     <= 4'b0000;
      o_Answer   <= ANS_IDLE;
      o_Unlocked <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      slots      <= slots_nxt;
      fails      <= fails_nxt;
      tmr        <= tmr_nxt;
      code       <= code_nxt;
      leds_q     <= leds_nxt;
      o_Answer   <= ans_nxt;
      o_Unlocked <= unl_nxt;
    end
  end

  assign {o_LED_4, o_LED_3, o_LED_2, o_LED_1} = leds_q;

endmodule

// File: tb/tb_passcode_lock_fsm.sv
// Scoreboard bench for passcode_lock_fsm. Stimulus pushes every expected output
// change (answer, LEDs, unlocked, and optionally how many clocks it must hold)
// before issuing the press; the monitor pops on each observed change.
module tb_passcode_lock_fsm;
  import passcode_lock_fsm_pkg::*;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Switch_Enter = 1'b0, i_Switch_Clear = 1'b0, i_Switch_Prog = 1'b0;
  logic [3:0] i_Digit = 4'd0;
  logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Unlocked;
  logic [2:0] o_Answer;

  passcode_lock_fsm #(
    .CODE(16'h1234), .MAX_FAILS(3), .OPEN_CLKS(20), .FAIL_CLKS(10), .LOCKOUT_CLKS(50)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L),
    .i_Switch_Enter(i_Switch_Enter), .i_Switch_Clear(i_Switch_Clear),
    .i_Switch_Prog(i_Switch_Prog), .i_Digit(i_Digit),
    .o_LED_1(o_LED_1), .o_LED_2(o_LED_2), .o_LED_3(o_LED_3), .o_LED_4(o_LED_4),
    .o_Answer(o_Answer), .o_Unlocked(o_Unlocked)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [2:0] ans;
    logic [3:0] leds;
    logic       unl;
    int         dur;   // clocks the state must hold; 0 = not checked
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;
  bit   done = 1'b0;

  wire [7:0] obs = {o_Answer, o_LED_4, o_LED_3, o_LED_2, o_LED_1, o_Unlocked};

  // Monitor: every comparison lives here.
  initial begin : monitor
    logic [7:0] last_obs;
    int   seg_len, seg_dur;
    exp_t e;
    seg_len = 0;
    seg_dur = 0;
    @(negedge i_Clk);
    n_tests++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got %b, want 00000000", obs);
    end
    last_obs = obs;
    forever begin
      @(negedge i_Clk);
      if (done) begin
        n_tests++;
        if (q.size() != 0) begin
          n_fail++;
          $display("FAIL pending: %0d expected changes never seen, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      if (obs !== last_obs) begin
        if (seg_dur != 0) begin
          n_tests++;
          if (seg_len != seg_dur) begin
            n_fail++;
            $display("FAIL hold ans=%0d: held %0d clocks, want %0d", last_obs[7:5], seg_len, seg_dur);
          end
        end
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected change: got ans=%0d leds=%b unl=%b, want no change",
                   obs[7:5], obs[4:1], obs[0]);
          seg_dur = 0;
        end else begin
          e = q.pop_front();
          if ({e.ans, e.leds, e.unl} !== obs) begin
            n_fail++;
            $display("FAIL output: got ans=%0d leds=%b unl=%b, want ans=%0d leds=%b unl=%b",
                     obs[7:5], obs[4:1], obs[0], e.ans, e.leds, e.unl);
          end
          seg_dur = e.dur;
        end
        last_obs = obs;
        seg_len  = 1;
      end else begin
        seg_len++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic push(input logic [2:0] a, input logic [3:0] l, input logic u, input int d);
    exp_t e;
    e.ans = a; e.leds = l; e.unl = u; e.dur = d;
    q.push_back(e);
  endtask

  task automatic push_idle();
    push(ANS_IDLE, 4'b0000, 1'b0, 0);
  endtask

  task automatic press_enter(input logic [3:0] d);
    @(negedge i_Clk); i_Digit = d; i_Switch_Enter = 1'b1;
    @(negedge i_Clk); i_Switch_Enter = 1'b0;
  endtask

  task automatic press_clear();
    @(negedge i_Clk); i_Switch_Clear = 1'b1;
    @(negedge i_Clk); i_Switch_Clear = 1'b0;
  endtask

  task automatic press_prog();
    @(negedge i_Clk); i_Switch_Prog = 1'b1;
    @(negedge i_Clk); i_Switch_Prog = 1'b0;
  endtask

  // Four digits entered in state st; fa/fd give the outcome after the 4th.
  task automatic code4(input logic [15:0] c, input logic [2:0] st,
                       input logic [2:0] fa, input int fd);
    push(st, 4'b0001, 1'b0, 0); press_enter(c[15:12]);
    push(st, 4'b0011, 1'b0, 0); press_enter(c[11:8]);
    push(st, 4'b0111, 1'b0, 0); press_enter(c[7:4]);
    push(fa, (fa == ANS_OPEN) ? 4'b1111 : 4'b0000, (fa == ANS_OPEN), fd);
    press_enter(c[3:0]);
  endtask

  initial begin : stim
    tick(3);
    i_Rst_L = 1'b1;
    tick(2);

    // correct code opens for 20 clocks
    code4(16'h1234, ANS_ENTRY, ANS_OPEN, 20); push_idle(); tick(25);

    // wrong code shows FAIL for 10, then correct code opens and clears the count
    code4(16'h1235, ANS_ENTRY, ANS_FAIL, 10); push_idle(); tick(14);
    code4(16'h1234, ANS_ENTRY, ANS_OPEN, 20); push_idle(); tick(25);

    // three wrong in a row -> lockout for 50; Enter ignored meanwhile
    code4(16'h1111, ANS_ENTRY, ANS_FAIL, 10); push_idle(); tick(14);
    code4(16'h5678, ANS_ENTRY, ANS_FAIL, 10); push_idle(); tick(14);
    code4(16'h0000, ANS_ENTRY, ANS_LOCKOUT, 50); push_idle();
    press_enter(4'd1); press_enter(4'd2); press_enter(4'd3);
    tick(50);

    // partial entry aborted by Clear, then correct code
    push(ANS_ENTRY, 4'b0001, 1'b0, 0); press_enter(4'd1);
    push(ANS_ENTRY, 4'b0011, 1'b0, 0); press_enter(4'd2);
    push_idle(); press_clear(); tick(3);
    code4(16'h1234, ANS_ENTRY, ANS_OPEN, 20); push_idle(); tick(25);

    // reprogram to 9876, old code fails, new code opens, reset restores 1234
    code4(16'h1234, ANS_ENTRY, ANS_OPEN, 0); tick(3);
    push(ANS_PROG, 4'b0000, 1'b0, 0); press_prog();
    code4(16'h9876, ANS_PROG, ANS_IDLE, 0); tick(3);
    code4(16'h1234, ANS_ENTRY, ANS_FAIL, 10); push_idle(); tick(14);
    code4(16'h9876, ANS_ENTRY, ANS_OPEN, 0); tick(3);
    push_idle();
    @(negedge i_Clk); i_Rst_L = 1'b0;
    @(negedge i_Clk); i_Rst_L = 1'b1;
    tick(2);
    code4(16'h1234, ANS_ENTRY, ANS_OPEN, 20); push_idle(); tick(25);

    // Clear and Enter rising together: Clear wins
    push(ANS_ENTRY, 4'b0001, 1'b0, 0); press_enter(4'd1);
    push_idle();
    @(negedge i_Clk); i_Digit = 4'd5; i_Switch_Enter = 1'b1; i_Switch_Clear = 1'b1;
    @(negedge i_Clk); i_Switch_Enter = 1'b0; i_Switch_Clear = 1'b0;
    tick(3);

    // Enter held high across reset release: no capture
    @(negedge i_Clk); i_Rst_L = 1'b0;
    @(negedge i_Clk); i_Switch_Enter = 1'b1; i_Digit = 4'd7;
    tick(2);
    i_Rst_L = 1'b1;
    tick(5);
    i_Switch_Enter = 1'b0;
    tick(2);
    push(ANS_ENTRY, 4'b0001, 1'b0, 0); press_enter(4'd3);
    push_idle(); press_clear(); tick(3);

    #1 done = 1'b1;
    tick(5);
    $display("FAIL watchdog: monitor did not finish, want summary");
    $fatal(1, "watchdog");
  end

endmodule
